cache_axi_arbiter: RTL and testbench

//  Shares one AXI4 master port between icache refill, dcache refill/writeback and dcache uncached access.

---
 rtl/cache_axi_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_cache_axi_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI4 master between icache refill, dcache refill/writeback and uncached access.
// Optional RAW_CHECK_EN: hold a read whose line matches a pending or in-flight write until its B response.
module cache_axi_arbiter #(
    parameter int LINE_WORDS = 8,
    parameter int ID_W       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ic_rd_req,
    input  logic [31:0]                ic_rd_addr,
    output logic                       ic_rd_rdy,
    output logic                       ic_ret_valid,
    output logic [LINE_WORDS*32-1:0]   ic_ret_data,
    input  logic                       dc_rd_req,
    input  logic [31:0]                dc_rd_addr,
    output logic                       dc_rd_rdy,
    output logic                       dc_ret_valid,
    output logic [LINE_WORDS*32-1:0]   dc_ret_data,
    input  logic                       dc_wr_req,
    input  logic [31:0]                dc_wr_addr,
    input  logic [LINE_WORDS*32-1:0]   dc_wr_data,
    output logic                       dc_wr_rdy,
    input  logic                       uc_ren,
    input  logic [31:0]                uc_araddr,
    output logic                       uc_rvalid,
    output logic [31:0]                uc_rdata,
    input  logic                       uc_wen,
    input  logic [31:0]                uc_awaddr,
    input  logic [31:0]                uc_wdata,
    input  logic [3:0]                 uc_wstrb,
    output logic                       uc_bvalid,
    output logic                       arvalid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [ID_W-1:0]            arid,
    input  logic                       arready,
    input  logic                       rvalid,
    input  logic [31:0]                rdata,
    input  logic                       rlast,
    input  logic [ID_W-1:0]            rid,
    output logic                       rready,
    output logic                       awvalid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    input  logic                       awready,
    output logic                       wvalid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    input  logic                       wready,
    input  logic                       bvalid,
    output logic                       bready
);
    localparam int LINE_W = LINE_WORDS * 32;
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);

    localparam logic [1:0] R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2, R_DONE = 2'd3;
    localparam logic [1:0] W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_RESP = 2'd3;
    localparam logic [1:0] SRC_IC = 2'd0, SRC_DC = 2'd1, SRC_UC = 2'd2;

    logic [1:0]       rstate, wstate;
    logic [1:0]       rd_src, want_src;
    logic [31:0]      rd_addr, want_addr;
    logic             rd_want, rd_hazard, rd_grant, ret_pulse;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic [LINE_W-1:0] rd_buf, ret_line;
    logic             rbeat_vld_p0, rbeat_last_p0;
    logic [31:0]      rbeat_data_p0;

    logic             wr_uc, wb_valid, wb_take, wr_grant_uc, wr_grant_dc;
    logic [31:0]      wr_addr, wr_udata, wb_addr, wb_word;
    logic [3:0]       wr_strb;
    logic [LINE_W-1:0] wb_data;

    logic             unused_rid;
    assign unused_rid = ^rid;

    always_comb begin
        rd_want   = 1'b0;
        want_src  = SRC_IC;
        want_addr = ic_rd_addr;
        if (uc_ren) begin
            rd_want   = 1'b1;
            want_src  = SRC_UC;
            want_addr = uc_araddr;
        end else if (dc_rd_req) begin
            rd_want   = 1'b1;
            want_src  = SRC_DC;
            want_addr = dc_rd_addr;
        end else if (ic_rd_req) begin
            rd_want   = 1'b1;
        end
    end

`ifdef RAW_CHECK_EN
    assign rd_hazard = (wb_valid && wb_addr[31:OFF_W] == want_addr[31:OFF_W])
                    || (wb_take && dc_wr_addr[31:OFF_W] == want_addr[31:OFF_W])
                    || (wstate != W_IDLE && wr_addr[31:OFF_W] == want_addr[31:OFF_W])
                    || (uc_wen && uc_awaddr[31:OFF_W] == want_addr[31:OFF_W]);
`else
    assign rd_hazard = 1'b0;
`endif

    // A requester is still high during its return pulse; skip that cycle so it is not re-granted.
    assign ret_pulse = ic_ret_valid | dc_ret_valid | uc_rvalid;
    assign rd_grant  = (rstate == R_IDLE) && rd_want && !rd_hazard && !ret_pulse;
    assign rready    = (rstate == R_DATA) && !(rbeat_vld_p0 && rbeat_last_p0);

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate       <= R_IDLE;
            rd_cnt       <= '0;
            rbeat_vld_p0 <= 1'b0;
            ic_rd_rdy    <= 1'b0;
            dc_rd_rdy    <= 1'b0;
            ic_ret_valid <= 1'b0;
            dc_ret_valid <= 1'b0;
            uc_rvalid    <= 1'b0;
        end else begin
            ic_rd_rdy    <= 1'b0;
            dc_rd_rdy    <= 1'b0;
            ic_ret_valid <= 1'b0;
            dc_ret_valid <= 1'b0;
            uc_rvalid    <= 1'b0;
            rbeat_vld_p0 <= rvalid && rready;
            case (rstate)
                R_IDLE: if (rd_grant) begin
                    rstate    <= R_AR;
                    rd_cnt    <= '0;
                    ic_rd_rdy <= (want_src == SRC_IC);
                    dc_rd_rdy <= (want_src == SRC_DC);
                end
                R_AR: if (arready) rstate <= R_DATA;
                R_DATA: if (rbeat_vld_p0) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rbeat_last_p0) rstate <= R_DONE;
                end
                default: begin
                    rstate       <= R_IDLE;
                    rd_cnt       <= '0;
                    ic_ret_valid <= (rd_src == SRC_IC);
                    dc_ret_valid <= (rd_src == SRC_DC);
                    uc_rvalid    <= (rd_src == SRC_UC);
                end
            endcase
        end
    end

    // R beat capture (p0), then line assembly one cycle later
    always_ff @(posedge clk) begin
        rbeat_data_p0 <= rdata;
        rbeat_last_p0 <= rlast;
        if (rd_grant) begin
            rd_src  <= want_src;
            rd_addr <= want_addr;
        end
        if (rstate == R_DONE) ret_line <= rd_buf;
        if (rstate != R_DATA) begin
            rd_buf <= '0;
        end else if (rbeat_vld_p0) begin
            for (int i = 0; i < LINE_WORDS; i++)
                if (rd_cnt == CNT_W'(i)) rd_buf[32*i +: 32] <= rbeat_data_p0;
        end
    end

    assign arvalid     = (rstate == R_AR);
    assign araddr      = !arvalid ? 32'd0 :
                         (rd_src == SRC_UC) ? rd_addr : {rd_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign arlen       = (arvalid && rd_src != SRC_UC) ? 8'(LINE_WORDS - 1) : 8'd0;
    assign arsize      = arvalid ? 3'd2 : 3'd0;
    assign arburst     = arvalid ? 2'b01 : 2'b00;
    assign arid        = arvalid ? ID_W'(rd_src) : '0;
    assign ic_ret_data = ic_ret_valid ? ret_line : '0;
    assign dc_ret_data = dc_ret_valid ? ret_line : '0;
    assign uc_rdata    = uc_rvalid ? ret_line[31:0] : 32'd0;

    assign dc_wr_rdy   = (wstate == W_IDLE) && !wb_valid;
    assign wb_take     = dc_wr_req && dc_wr_rdy;
    assign wr_grant_uc = (wstate == W_IDLE) && uc_wen && !uc_bvalid;
    assign wr_grant_dc = (wstate == W_IDLE) && !uc_wen && wb_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate    <= W_IDLE;
            wr_uc     <= 1'b0;
            wr_cnt    <= '0;
            wb_valid  <= 1'b0;
            uc_bvalid <= 1'b0;
        end else begin
            uc_bvalid <= 1'b0;
            if (wb_take) wb_valid <= 1'b1;
            case (wstate)
                W_IDLE: if (wr_grant_uc || wr_grant_dc) begin
                    wstate <= W_AW;
                    wr_uc  <= wr_grant_uc;
                end
                W_AW: if (awready) begin
                    wstate <= W_DATA;
                    wr_cnt <= '0;
                end
                W_DATA: if (wready) begin
                    if (wlast) wstate <= W_RESP;
                    else       wr_cnt <= wr_cnt + 1'b1;
                end
                default: if (bvalid) begin
                    wstate <= W_IDLE;
                    if (wr_uc) uc_bvalid <= 1'b1;
                    else       wb_valid  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wb_take) begin
            wb_addr <= dc_wr_addr;
            wb_data <= dc_wr_data;
        end
        if (wr_grant_uc) begin
            wr_addr  <= uc_awaddr;
            wr_udata <= uc_wdata;
            wr_strb  <= uc_wstrb;
        end else if (wr_grant_dc) begin
            wr_addr  <= wb_addr;
        end
    end

    always_comb begin
        wb_word = 32'd0;
        for (int i = 0; i < LINE_WORDS; i++)
            if (wr_cnt == CNT_W'(i)) wb_word = wb_data[32*i +: 32];
    end

    assign awvalid = (wstate == W_AW);
    assign awaddr  = !awvalid ? 32'd0 : wr_uc ? wr_addr : {wr_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign awlen   = (awvalid && !wr_uc) ? 8'(LINE_WORDS - 1) : 8'd0;
    assign awsize  = awvalid ? 3'd2 : 3'd0;
    assign awburst = awvalid ? 2'b01 : 2'b00;
    assign wvalid  = (wstate == W_DATA);
    assign wdata   = !wvalid ? 32'd0 : wr_uc ? wr_udata : wb_word;
    assign wstrb   = !wvalid ? 4'd0 : wr_uc ? wr_strb : 4'hf;
    assign wlast   = wvalid && (wr_uc || wr_cnt == CNT_W'(LINE_WORDS - 1));
    assign bready  = (wstate == W_RESP);

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter with an inline AXI slave and expected-value queues.
module tb_cache_axi_arbiter;
    logic clk = 1'b0, reset;
    logic ic_rd_req, ic_rd_rdy, ic_ret_valid, dc_rd_req, dc_rd_rdy, dc_ret_valid;
    logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, uc_araddr, uc_rdata, uc_awaddr, uc_wdata;
    logic [255:0] ic_ret_data, dc_ret_data, dc_wr_data;
    logic dc_wr_req, dc_wr_rdy, uc_ren, uc_rvalid, uc_wen, uc_bvalid;
    logic [3:0] uc_wstrb, arid, rid, wstrb;
    logic arvalid, arready, rvalid, rlast, rready, awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0] arlen, awlen;
    logic [2:0] arsize, awsize;
    logic [1:0] arburst, awburst;

    int total = 0;
    int bad = 0;
    logic [255:0] rq[$];
    logic [36:0]  wq[$];

    cache_axi_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .uc_ren(uc_ren), .uc_araddr(uc_araddr), .uc_rvalid(uc_rvalid), .uc_rdata(uc_rdata),
        .uc_wen(uc_wen), .uc_awaddr(uc_awaddr), .uc_wdata(uc_wdata), .uc_wstrb(uc_wstrb), .uc_bvalid(uc_bvalid),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arid(arid), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rid(rid), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    function automatic logic ret_sig(input int sel);
        return (sel == 0) ? ic_ret_valid : (sel == 1) ? dc_ret_valid : uc_rvalid;
    endfunction

    function automatic logic [255:0] ret_dat(input int sel);
        return (sel == 0) ? ic_ret_data : (sel == 1) ? dc_ret_data : {224'd0, uc_rdata};
    endfunction

    task automatic wait_ret(input string tag, input int sel);
        int n;
        logic [255:0] e;
        n = 0;
        while (!ret_sig(sel) && n < 40) begin @(negedge clk); n++; end
        chk({tag, " ret_valid"}, ret_sig(sel), 1'b1);
        e = '0;
        if (rq.size() > 0) e = rq.pop_front();
        chk({tag, " ret_data"}, ret_dat(sel), e);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] base, input int nbeats, input bit fin);
        int n;
        n = 0;
        while (!arvalid && n < 40) begin @(negedge clk); n++; end
        chk({tag, " arvalid"}, arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            rvalid = 1'b1;
            rdata  = base + 32'(i);
            rlast  = fin && (i == nbeats - 1);
            n = 0;
            while (!rready && n < 40) begin @(negedge clk); n++; end
            chk({tag, " rready"}, rready, 1'b1);
            @(negedge clk);
        end
        if (fin) begin rvalid = 1'b0; rlast = 1'b0; end
    endtask

    task automatic axi_write(input string tag, input logic [31:0] eaddr, input logic [7:0] elen, input int nbeats);
        int n;
        logic [36:0] e;
        n = 0;
        while (!awvalid && n < 40) begin @(negedge clk); n++; end
        chk({tag, " awvalid"}, awvalid, 1'b1);
        chk({tag, " awaddr"}, awaddr, eaddr);
        chk({tag, " awlen"}, awlen, elen);
        chk({tag, " awsize/burst"}, {awsize, awburst}, 5'b010_01);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            n = 0;
            while (!wvalid && n < 40) begin @(negedge clk); n++; end
            e = '0;
            if (wq.size() > 0) e = wq.pop_front();
            chk({tag, " wbeat"}, {wvalid, wlast, wstrb, wdata}, {1'b1, e});
            @(negedge clk);
        end
        wready = 1'b0;
        bvalid = 1'b1;
        n = 0;
        while (!bready && n < 40) begin @(negedge clk); n++; end
        chk({tag, " bready"}, bready, 1'b1);
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ic_rd_req = 0; ic_rd_addr = 0; dc_rd_req = 0; dc_rd_addr = 0;
        dc_wr_req = 0; dc_wr_addr = 0; dc_wr_data = 0;
        uc_ren = 0; uc_araddr = 0; uc_wen = 0; uc_awaddr = 0; uc_wdata = 0; uc_wstrb = 0;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0; awready = 0; wready = 0; bvalid = 0;
        repeat (3) @(negedge clk);
        chk("reset valids", {arvalid, rready, awvalid, wvalid, bready, ic_rd_rdy, dc_rd_rdy,
                             ic_ret_valid, dc_ret_valid, uc_rvalid, uc_bvalid}, 11'd0);
        chk("reset dc_wr_rdy", dc_wr_rdy, 1'b1);
        chk("reset data", {araddr, arlen, arid, awaddr, wdata, uc_rdata}, 140'd0);
        reset = 1'b0;
        @(negedge clk);

        // ic and dc together: dc wins
        ic_rd_req = 1; ic_rd_addr = 32'h1c000040;
        dc_rd_req = 1; dc_rd_addr = 32'h1c000040;
        @(negedge clk);
        chk("prio rdy", {dc_rd_rdy, ic_rd_rdy}, 2'b10);
        chk("prio ar", {arvalid, araddr, arlen, arsize, arburst, arid},
            {1'b1, 32'h1c000040, 8'd7, 3'd2, 2'b01, 4'd1});
        rq.push_back(mk_line(32'd0));
        axi_read("dc line", 32'd0, 8, 1'b1);
        chk("dc ret t+1", dc_ret_valid, 1'b0);
        @(negedge clk);
        chk("dc ret t+2", dc_ret_valid, 1'b0);
        @(negedge clk);
        wait_ret("dc line", 1);
        chk("dc ret ic idle", ic_ret_valid, 1'b0);
        dc_rd_req = 0;
        @(negedge clk);
        chk("dc ret pulse", dc_ret_valid, 1'b0);
        n = 0;
        while (!ic_rd_rdy && n < 20) begin @(negedge clk); n++; end
        chk("ic grant", {ic_rd_rdy, arvalid, araddr, arid}, {1'b1, 1'b1, 32'h1c000040, 4'd0});
        rq.push_back(mk_line(32'h100));
        axi_read("ic line", 32'h100, 8, 1'b1);
        wait_ret("ic line", 0);
        ic_rd_req = 0;
        @(negedge clk);

        // uncached single-beat read
        uc_ren = 1; uc_araddr = 32'hbfaf8000;
        @(negedge clk);
        chk("uc ar", {arvalid, araddr, arlen, arid}, {1'b1, 32'hbfaf8000, 8'd0, 4'd2});
        rq.push_back(256'h12345678);
        axi_read("uc rd", 32'h12345678, 1, 1'b1);
        wait_ret("uc rd", 2);
        uc_ren = 0;
        @(negedge clk);

        // writeback and uncached write together: uncached first
        chk("wr rdy idle", dc_wr_rdy, 1'b1);
        uc_wen = 1; uc_awaddr = 32'h40; uc_wdata = 32'hdeadbeef; uc_wstrb = 4'h3;
        dc_wr_req = 1; dc_wr_addr = 32'h00001000; dc_wr_data = mk_line(32'ha0);
        wq.push_back({1'b1, 4'h3, 32'hdeadbeef});
        @(negedge clk);
        dc_wr_req = 0;
        chk("wr rdy busy", dc_wr_rdy, 1'b0);
        axi_write("uc wr", 32'h40, 8'd0, 1);
        chk("uc bvalid", uc_bvalid, 1'b1);
        chk("wr rdy pending", dc_wr_rdy, 1'b0);
        uc_wen = 0;
        for (int i = 0; i < 8; i++) wq.push_back({i == 7, 4'hf, 32'ha0 + 32'(i)});
        axi_write("dc wr", 32'h00001000, 8'd7, 8);
        chk("dc wr done", {dc_wr_rdy, uc_bvalid}, 2'b10);

        // read-after-write line overlap
        dc_wr_req = 1; dc_wr_addr = 32'h2000; dc_wr_data = mk_line(32'hb0);
        @(negedge clk);
        dc_wr_req = 0;
        dc_rd_req = 1; dc_rd_addr = 32'h2004;
        @(negedge clk);
        for (int i = 0; i < 8; i++) wq.push_back({i == 7, 4'hf, 32'hb0 + 32'(i)});
        rq.push_back(mk_line(32'h300));
`ifdef RAW_CHECK_EN
        chk("raw held", arvalid, 1'b0);
        repeat (3) @(negedge clk);
        chk("raw still held", arvalid, 1'b0);
        axi_write("raw wr", 32'h2000, 8'd7, 8);
        n = 0;
        while (!arvalid && n < 20) begin @(negedge clk); n++; end
        chk("raw ar after b", {arvalid, araddr}, {1'b1, 32'h2000});
        axi_read("raw rd", 32'h300, 8, 1'b1);
        wait_ret("raw rd", 1);
        dc_rd_req = 0;
`else
        chk("raw ar immediate", {arvalid, araddr, arlen}, {1'b1, 32'h2000, 8'd7});
        axi_read("raw rd", 32'h300, 8, 1'b1);
        wait_ret("raw rd", 1);
        dc_rd_req = 0;
        axi_write("raw wr", 32'h2000, 8'd7, 8);
`endif
        chk("raw wr rdy", dc_wr_rdy, 1'b1);

        // reset in the middle of a burst
        ic_rd_req = 1; ic_rd_addr = 32'h3000;
        axi_read("mid rst", 32'h500, 3, 1'b0);
        reset = 1; rvalid = 0; ic_rd_req = 0;
        @(negedge clk);
        chk("mid rst valids", {arvalid, rready, awvalid, wvalid, bready, ic_rd_rdy, ic_ret_valid}, 7'd0);
        chk("mid rst wr rdy", dc_wr_rdy, 1'b1);
        reset = 0;
        @(negedge clk);
        ic_rd_req = 1; ic_rd_addr = 32'h4010;
        @(negedge clk);
        chk("post rst ar", {ic_rd_rdy, arvalid, araddr, arid}, {1'b1, 1'b1, 32'h4000, 4'd0});
        rq.push_back(mk_line(32'h600));
        axi_read("post rst", 32'h600, 8, 1'b1);
        wait_ret("post rst", 0);
        ic_rd_req = 0;
        @(negedge clk);
        chk("queues empty", {rq.size() == 0, wq.size() == 0}, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
